ssd_bcd_scan: RTL and testbench

Downstream consumer of the 8-bit free-running counter. Converts the counter value into three decimal digits with a sequential double-dabble engine. Drives a 4-digit, common-anode seven-segment display by time-multiplexing the digits. Shares the counter's clock domain. The display register is updated atomically, so digits never show a mix of old and new values.

---
 rtl/ssd_bcd_scan.sv | 149 ++++++++++++++
 tb/tb_ssd_bcd_scan.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_bcd_scan.sv
// Binary-to-BCD display driver: a sequential double-dabble engine converts the
// 8-bit count into three decimal digits, which are time-multiplexed onto a 4-digit display.
module ssd_bcd_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic [7:0] count,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy,
    output logic       upd
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t           state_q, state_d;
    logic [19:0]      sr_q, sr_d;
    logic [2:0]       iter_q, iter_d;
    logic             load_disp;
    logic [3:0]       h_q, t_q, o_q;
    logic             upd_q;
    logic [CNT_W-1:0] refresh_q;
    logic [1:0]       sel_q;
    logic [6:0]       seg_d, seg_q;
    logic [3:0]       an_q;

    // One double-dabble iteration: correct each BCD nibble, then shift in the next bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            iter_q  <= '0;
            h_q     <= '0;
            t_q     <= '0;
            o_q     <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
            upd_q   <= load_disp;
            if (load_disp) begin
                {h_q, t_q, o_q} <= sr_q[19:8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        iter_d    = iter_q;
        load_disp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sr_d    = {12'd0, count};
                iter_d  = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_d   = dabble_step(sr_q);
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                load_disp = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Digit scan: sel advances once per REFRESH_DIV cycles.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            refresh_q <= '0;
            sel_q     <= '0;
        end else if (refresh_q == CNT_MAX) begin
            refresh_q <= '0;
            sel_q     <= sel_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        case (sel_q)
            2'd0: seg_d = seg_decode(o_q);
            2'd1: seg_d = (BLANK_LZ && h_q == 4'd0 && t_q == 4'd0) ? SEG_BLANK : seg_decode(t_q);
            2'd2: seg_d = (BLANK_LZ && h_q == 4'd0) ? SEG_BLANK : seg_decode(h_q);
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
        end else begin
            seg_q <= seg_d;
            an_q  <= ~(4'b0001 << sel_q);
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;
    assign busy = (state_q != ST_IDLE);
    assign upd  = upd_q;

endmodule

// File: tb/tb_ssd_bcd_scan.sv
// Bench for ssd_bcd_scan: random and directed counts checked against a decimal
// arithmetic model of the displayed digits, plus reset and cadence checks.
`timescale 1ns/1ps
module tb_ssd_bcd_scan;

    localparam int RDIV = 4;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic [7:0] count;
    logic [6:0] seg, seg_nlz;
    logic [3:0] an, an_nlz;
    logic       dp, dp_nlz, busy, busy_nlz, upd, upd_nlz;

    int total = 0;
    int bad   = 0;

    always #5 clock_in = ~clock_in;

    ssd_bcd_scan #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b1)) dut (
        .clock_in(clock_in), .reset_n(reset_n), .count(count),
        .seg(seg), .dp(dp), .an(an), .busy(busy), .upd(upd)
    );

    ssd_bcd_scan #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b0)) dut_nlz (
        .clock_in(clock_in), .reset_n(reset_n), .count(count),
        .seg(seg_nlz), .dp(dp_nlz), .an(an_nlz), .busy(busy_nlz), .upd(upd_nlz)
    );

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected segments for a digit position of value v (0 = ones ... 3 = unused).
    function automatic logic [6:0] exp_seg(int v, int pos, bit blz);
        int h = v / 100;
        int t = (v / 10) % 10;
        int o = v % 10;
        case (pos)
            0: return seg_of(o);
            1: return (blz && h == 0 && t == 0) ? 7'h7F : seg_of(t);
            2: return (blz && h == 0) ? 7'h7F : seg_of(h);
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int pos_of(logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check_slot(string tag, int v);
        int pos;
        pos = pos_of(an);
        total++;
        if (pos < 0) begin
            bad++;
            $display("FAIL %s: an=%b required one-hot-zero", tag, an);
        end else begin
            if (seg !== exp_seg(v, pos, 1'b1)) begin
                bad++;
                $display("FAIL %s: v=%0d pos=%0d seg=%b required %b", tag, v, pos, seg, exp_seg(v, pos, 1'b1));
            end
            total++;
            if (seg_nlz !== exp_seg(v, pos, 1'b0)) begin
                bad++;
                $display("FAIL %s_nlz: v=%0d pos=%0d seg=%b required %b", tag, v, pos, seg_nlz, exp_seg(v, pos, 1'b0));
            end
        end
    endtask

    task automatic wait_upd(string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 25 && !seen; k++) begin
            @(negedge clock_in);
            seen = upd;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: upd=0 after 25 cycles required 1", tag);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        total++;
        if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0 || upd !== 1'b0 || dp !== 1'b1) begin
            bad++;
            $display("FAIL %s: seg=%h an=%b busy=%b upd=%b dp=%b required 7f 1111 0 0 1",
                     tag, seg, an, busy, upd, dp);
        end
    endtask

    // Releases reset with count = v and checks the first conversion cadence.
    task automatic release_check(string tag, int v);
        logic exp_upd, exp_busy;
        @(negedge clock_in);
        count   = 8'(v);
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock_in);
            if (k == 1) begin
                total++;
                if (an !== 4'b1110 || seg !== 7'b1000000) begin
                    bad++;
                    $display("FAIL %s_first_edge: an=%b seg=%b required 1110 1000000", tag, an, seg);
                end
            end
            if (k <= 10) begin
                exp_upd  = (k == 10);
                exp_busy = (k < 10);
                total++;
                if (upd !== exp_upd || busy !== exp_busy) begin
                    bad++;
                    $display("FAIL %s_cadence: cycle %0d upd=%b busy=%b required %b %b",
                             tag, k, upd, busy, exp_upd, exp_busy);
                end
            end
            if (k == 11) check_slot({tag, "_digit"}, v);
        end
    endtask

    task automatic test_reset();
        @(posedge clock_in);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        repeat (3) @(posedge clock_in);
        #1;
        check_reset_outputs("reset_held");
        release_check("reset_release", 0);
    endtask

    task automatic test_digits(int v);
        @(negedge clock_in);
        count = 8'(v);
        wait_upd("digits_upd1");
        wait_upd("digits_upd2");
        for (int k = 0; k < 4 * RDIV; k++) begin
            @(negedge clock_in);
            check_slot("digits", v);
        end
    endtask

    task automatic test_scan_timing();
        logic [3:0] prev;
        int run;
        bit seen;
        @(negedge clock_in);
        prev = an;
        run  = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock_in);
            if (an === prev) begin
                run++;
            end else begin
                total++;
                if (an !== {prev[2:0], prev[3]}) begin
                    bad++;
                    $display("FAIL scan_order: an=%b after %b required %b", an, prev, {prev[2:0], prev[3]});
                end
                if (seen) begin
                    total++;
                    if (run != RDIV) begin
                        bad++;
                        $display("FAIL scan_slot_len: an=%b held %0d cycles required %0d", prev, run, RDIV);
                    end
                end
                seen = 1'b1;
                prev = an;
                run  = 1;
            end
        end
    endtask

    task automatic test_ignore();
        int v1, v2;
        v1 = $urandom_range(0, 255);
        v2 = (v1 + 1 + $urandom_range(0, 253)) % 256;
        wait_upd("ignore_sync");
        count = 8'(v1);
        @(negedge clock_in);
        count = 8'(v2);
        repeat (9) @(negedge clock_in);
        total++;
        if (upd !== 1'b1) begin
            bad++;
            $display("FAIL ignore_upd: upd=%b required 1", upd);
        end
        @(negedge clock_in);
        check_slot("ignore_v1", v1);
        wait_upd("ignore_next");
        @(negedge clock_in);
        check_slot("ignore_v2", v2);
    endtask

    task automatic test_counter();
        int drv[$];
        int n_upd, pend_v;
        bit pending;
        n_upd   = 0;
        pending = 1'b0;
        pend_v  = 0;
        @(negedge clock_in);
        count = 8'd235;
        for (int n = 0; n < 220; n++) begin
            @(negedge clock_in);
            if (pending) begin
                check_slot("counter", pend_v);
                pending = 1'b0;
            end
            if (upd && drv.size() >= 10) begin
                pend_v  = drv[drv.size() - 10];
                pending = 1'b1;
                n_upd++;
            end
            count = count + 8'd1;
            drv.push_back(int'(count));
        end
        total++;
        if (n_upd < 18) begin
            bad++;
            $display("FAIL counter_upd_count: %0d pulses required >= 18", n_upd);
        end
    endtask

    task automatic test_mid_reset();
        int v;
        wait_upd("midreset_sync");
        repeat (5) @(negedge clock_in);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_busy: busy=%b required 1", busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset_async");
        repeat (3) @(posedge clock_in);
        v = $urandom_range(1, 255);
        release_check("midreset_release", v);
    endtask

    initial begin
        reset_n = 1'b0;
        count   = 8'd0;
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
        repeat (7) @(negedge clock_in);

        test_reset();
        test_digits(255);
        test_scan_timing();
        test_digits(7);
        test_digits(100);
        test_digits(0);
        for (int r = 0; r < 4; r++) begin
            test_digits($urandom_range(0, 255));
        end
        test_ignore();
        test_counter();
        test_mid_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
